// File: rtl/reg8_async_rst.sv
// rtl/reg8_async_rst.sv - parallel-load D register with asynchronous active-low reset
module reg8_async_rst #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    // q comes straight off the flops; d never reaches it combinationally
    assign q = q_q;

endmodule

// File: tb/tb_reg8_async_rst.sv
// tb/tb_reg8_async_rst.sv - directed self-checking bench for reg8_async_rst
module tb_reg8_async_rst;

    logic        clk;
    logic        rst8;
    logic        rst16;
    logic [7:0]  d8;
    logic [7:0]  q8;
    logic [15:0] d16;
    logic [15:0] q16;

    int n_checks = 0;
    int n_fail   = 0;

    reg8_async_rst u_dut8 (
        .clk   (clk),
        .rst_n (rst8),
        .d     (d8),
        .q     (q8)
    );

    reg8_async_rst #(.WIDTH(16), .RST_VAL(16'hBEEF)) u_dut16 (
        .clk   (clk),
        .rst_n (rst16),
        .d     (d16),
        .q     (q16)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // t=0 .. t=2: reset asserted with no clock edge yet
    task automatic test_reset();
        rst8  = 1'b1;
        rst16 = 1'b1;
        d8    = 8'h01;
        d16   = 16'h1234;
        #1;
        rst8  = 1'b0;
        rst16 = 1'b0;
        #1;
        n_checks++;
        if (q8 !== 8'h00) begin
            n_fail++; $display("FAIL reset_q8: got %h expected 00", q8);
        end
        n_checks++;
        if (q16 !== 16'hBEEF) begin
            n_fail++; $display("FAIL reset_q16: got %h expected beef", q16);
        end
    endtask

    // absolute timeline from t=2: release at 5, edges at 10, 30, 50, 70, 90
    task automatic test_capture();
        #3;
        rst8  = 1'b1;
        rst16 = 1'b1;
        #6;  // t=11
        n_checks++;
        if (q8 !== 8'h01) begin
            n_fail++; $display("FAIL cap_t10: got %h expected 01", q8);
        end
        n_checks++;
        if (q16 !== 16'h1234) begin
            n_fail++; $display("FAIL cap16_t10: got %h expected 1234", q16);
        end
        #10; // t=21, negedge at 20 passed
        n_checks++;
        if (q8 !== 8'h01) begin
            n_fail++; $display("FAIL negedge_hold: got %h expected 01", q8);
        end
        #4;  // t=25
        d8  = 8'h02;
        d16 = 16'hABCD;
        #6;  // t=31
        n_checks++;
        if (q8 !== 8'h02) begin
            n_fail++; $display("FAIL cap_t30: got %h expected 02", q8);
        end
        n_checks++;
        if (q16 !== 16'hABCD) begin
            n_fail++; $display("FAIL cap16_t30: got %h expected abcd", q16);
        end
        #14; // t=45
        d8  = 8'h99;
        d16 = 16'h8001;
        #6;  // t=51
        n_checks++;
        if (q8 !== 8'h99) begin
            n_fail++; $display("FAIL cap_t50: got %h expected 99", q8);
        end
        n_checks++;
        if (q16 !== 16'h8001) begin
            n_fail++; $display("FAIL cap16_t50: got %h expected 8001", q16);
        end
        #40; // t=91
        n_checks++;
        if (q8 !== 8'h99) begin
            n_fail++; $display("FAIL cap_t90: got %h expected 99", q8);
        end
    endtask

    task automatic test_mid_cycle();
        @(posedge clk); #1;
        d8 = 8'hAA;
        @(negedge clk);
        d8 = 8'h55;
        #3;
        d8 = 8'hAA;
        #2;
        n_checks++;
        if (q8 !== 8'h99) begin
            n_fail++; $display("FAIL mid_no_change: got %h expected 99", q8);
        end
        @(posedge clk); #1;
        n_checks++;
        if (q8 !== 8'hAA) begin
            n_fail++; $display("FAIL mid_edge_aa: got %h expected aa", q8);
        end
        d8 = 8'h55;
        #4;
        d8 = 8'hAA;
        #4;
        d8 = 8'h55;
        @(posedge clk); #1;
        n_checks++;
        if (q8 !== 8'h55) begin
            n_fail++; $display("FAIL mid_edge_55: got %h expected 55", q8);
        end
    endtask

    task automatic test_async_reset();
        d8 = 8'h99;
        @(posedge clk); #1;
        n_checks++;
        if (q8 !== 8'h99) begin
            n_fail++; $display("FAIL ar_preload: got %h expected 99", q8);
        end
        #3;
        rst8 = 1'b0;
        #1;
        n_checks++;
        if (q8 !== 8'h00) begin
            n_fail++; $display("FAIL ar_immediate: got %h expected 00", q8);
        end
        d8 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (q8 !== 8'h00) begin
                n_fail++; $display("FAIL ar_hold%0d: got %h expected 00", i, q8);
            end
        end
    endtask

    task automatic test_reset_release();
        d8 = 8'h3C;
        #4;
        rst8 = 1'b1;
        #2;
        n_checks++;
        if (q8 !== 8'h00) begin
            n_fail++; $display("FAIL rel_before_edge: got %h expected 00", q8);
        end
        @(posedge clk); #1;
        n_checks++;
        if (q8 !== 8'h3C) begin
            n_fail++; $display("FAIL rel_first_edge: got %h expected 3c", q8);
        end
    endtask

    task automatic test_walking_one();
        logic [7:0] prev;
        logic [7:0] pat;
        prev = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            pat = 8'h01 << i;
            d8  = pat;
            #5;
            n_checks++;
            if (q8 !== prev) begin
                n_fail++; $display("FAIL walk_pre%0d: got %h expected %h", i, q8, prev);
            end
            @(posedge clk); #1;
            n_checks++;
            if (q8 !== pat) begin
                n_fail++; $display("FAIL walk_bit%0d: got %h expected %h", i, q8, pat);
            end
            prev = pat;
        end
    endtask

    task automatic test_wide();
        d16 = 16'hA5C3;
        @(posedge clk); #1;
        n_checks++;
        if (q16 !== 16'hA5C3) begin
            n_fail++; $display("FAIL wide_cap: got %h expected a5c3", q16);
        end
        #4;
        rst16 = 1'b0;
        #1;
        n_checks++;
        if (q16 !== 16'hBEEF) begin
            n_fail++; $display("FAIL wide_ar: got %h expected beef", q16);
        end
        d16 = 16'hFFFF;
        @(posedge clk); #1;
        n_checks++;
        if (q16 !== 16'hBEEF) begin
            n_fail++; $display("FAIL wide_ar_hold: got %h expected beef", q16);
        end
        d16 = 16'h3C3C;
        #4;
        rst16 = 1'b1;
        #2;
        n_checks++;
        if (q16 !== 16'hBEEF) begin
            n_fail++; $display("FAIL wide_rel_pre: got %h expected beef", q16);
        end
        @(posedge clk); #1;
        n_checks++;
        if (q16 !== 16'h3C3C) begin
            n_fail++; $display("FAIL wide_rel_cap: got %h expected 3c3c", q16);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_mid_cycle();
        test_async_reset();
        test_reset_release();
        test_walking_one();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
